// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared constants, state encoding and GF(2^8)/S-box helpers for the AES-128 key schedule
package aes_key_pkg;

    localparam logic [3:0] ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        EMIT
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constants for rounds 1..10; any other index yields 0.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; constant b folds down to a few xtime stages.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_dec_key_generator_inv_mixcol_word.sv
// aes_inv_mixcol_word: InvMixColumns applied to one 32-bit column (byte 0 in bits [31:24])
//   col_i  input column
//   col_o  transformed column
module aes_inv_mixcol_word
    import aes_key_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;
    assign col_o = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };

endmodule

// File: rtl/g_function.sv
// g_function: AES key-schedule g(): RotWord, SubWord, then XOR rcon into the top byte
//   word_i  32-bit input word
//   rcon_i  round constant byte
//   word_o  transformed word
module g_function
    import aes_key_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  rcon_i,
    output logic [31:0] word_o
);

    logic [31:0] rot;

    assign rot    = {word_i[23:0], word_i[31:24]};
    assign word_o = {sbox(rot[31:24]) ^ rcon_i, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes_dec_key_generator.sv
// aes_dec_key_generator: on-the-fly AES-128 decryption key schedule, emits k10..k0 over valid/ready
//   clk, rst              clock; asynchronous active-low reset
//   start_i, key_i        schedule request (sampled in IDLE) and cipher key k0
//   round_key_o           current round key, round_idx_o its round number (10..0)
//   round_key_valid_o     key/index valid; round_key_ready_i consumer accepts
//   busy_o, done_o        not-IDLE flag; one-cycle pulse after k0 is accepted
// Optional macro INV_MIXCOL_KEY_EN: rounds 9..1 are emitted through InvMixColumns
// for the equivalent inverse cipher; the working register always holds raw keys.
module aes_dec_key_generator
    import aes_key_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BLOCK_LENGTH-1:0] key_i,
    output logic [BLOCK_LENGTH-1:0] round_key_o,
    output logic                    round_key_valid_o,
    input  logic                    round_key_ready_i,
    output logic [3:0]              round_idx_o,
    output logic                    busy_o,
    output logic                    done_o
);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  g_in, g_out;
    logic [7:0]   g_rcon;
    logic [127:0] fwd_key, inv_key;

    assign {w0, w1, w2, w3} = work_q;

    // One g() instance shared by both directions: forward uses w3 with
    // rcon[cnt+1], inverse recovers the previous w3 as w7^w6 and uses rcon[cnt].
    assign g_in   = (state_q == EXPAND) ? w3 : (w3 ^ w2);
    assign g_rcon = rcon((state_q == EXPAND) ? cnt_q + 4'd1 : cnt_q);

    g_function u_g (
        .word_i (g_in),
        .rcon_i (g_rcon),
        .word_o (g_out)
    );

    always_comb begin
        fwd_key[127:96] = w0 ^ g_out;
        fwd_key[95:64]  = w1 ^ fwd_key[127:96];
        fwd_key[63:32]  = w2 ^ fwd_key[95:64];
        fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    end

    assign inv_key = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d  = key_i;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                work_d = fwd_key;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == ROUNDS - 4'd1) state_d = EMIT;
            end
            EMIT: begin
                if (round_key_ready_i) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        work_d = inv_key;
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            done_q  <= done_d;
        end
    end

`ifdef INV_MIXCOL_KEY_EN
    logic [127:0] imc_key;

    for (genvar i = 0; i < 4; i++) begin : g_imc
        aes_inv_mixcol_word u_imc (
            .col_i (work_q[127-32*i -: 32]),
            .col_o (imc_key[127-32*i -: 32])
        );
    end

    // k10 and k0 bracket the cipher as plain AddRoundKey and stay raw.
    assign round_key_o = (cnt_q != 4'd0 && cnt_q != ROUNDS) ? imc_key : work_q;
`else
    assign round_key_o = work_q;
`endif

    assign round_key_valid_o = (state_q == EMIT);
    assign round_idx_o       = cnt_q;
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;

endmodule
